iter_alu: RTL



---
 rtl/iter_alu.sv | 123 ++++++++++++
 1 files changed

// File: rtl/iter_alu.sv
// iter_alu: handshaked ALU with optional iterative mul/div path, enabled by defining ITER_ALU_MULDIV_EN
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic accept, is_md, calc_done, load;
  logic [SHW-1:0] shamt;
  logic [WIDTH-1:0] simple_res, md_res, load_val;
  assign accept = in_valid && state == IDLE;
  assign shamt = src_b[SHW-1:0];
  // Single-cycle ops; reserved and (when disabled) mul/div codes fall to 0
  always_comb begin
    simple_res = '0;
    case (alu_op)
      4'b0000: simple_res = src_a + src_b;
      4'b0001: simple_res = src_a - src_b;
      4'b0010: simple_res = src_a & src_b;
      4'b0011: simple_res = src_a | src_b;
      4'b0100: simple_res = src_a ^ src_b;
      4'b0101: simple_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'b0110: simple_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
      4'b0111: simple_res = src_a << shamt;
      4'b1000: simple_res = src_a >> shamt;
      4'b1001: simple_res = $signed(src_a) >>> shamt;
      default: simple_res = '0;
    endcase
  end
`ifdef ITER_ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
  logic [SHW-1:0] cnt;
  logic [1:0] md_op;
  logic [WIDTH-1:0] opnd, quo, quo_nx;
  logic [2*WIDTH:0] prod, prod_nx;
  logic [WIDTH:0] prod_add, rem, rem_sh, rem_nx;
  logic ge;
  assign is_md = alu_op >= 4'b1010 && alu_op <= 4'b1101;
  assign calc_done = state == CALC && cnt == SHW'(WIDTH - 1);
  assign prod_add = prod[2*WIDTH:WIDTH] + {1'b0, opnd};
  assign prod_nx = {1'b0, prod[0] ? prod_add : prod[2*WIDTH:WIDTH], prod[WIDTH-1:1]};
  assign rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign ge = rem_sh >= {1'b0, opnd};
  assign rem_nx = ge ? rem_sh - {1'b0, opnd} : rem_sh;
  assign quo_nx = {quo[WIDTH-2:0], ge};
  assign md_res = md_op[1] ? (md_op[0] ? prod_nx[2*WIDTH-1:WIDTH] : prod_nx[WIDTH-1:0])
                           : (md_op[0] ? rem_nx[WIDTH-1:0] : quo_nx);
  // Iterative engine: latch operands on accept, one shift-add/restore-subtract step per CALC cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      md_op <= '0;
      opnd <= '0;
      prod <= '0;
      rem <= '0;
      quo <= '0;
    end else if (accept) begin
      cnt <= '0;
      md_op <= alu_op[1:0];
      opnd <= alu_op[1] ? src_a : src_b;
      prod <= {{(WIDTH+1){1'b0}}, src_b};
      rem <= '0;
      quo <= src_a;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      prod <= prod_nx;
      rem <= rem_nx;
      quo <= quo_nx;
    end
  end
`else
  localparam bit MD_EN = 1'b0;
  assign is_md = 1'b0;
  assign calc_done = 1'b0;
  assign md_res = '0;
`endif
  assign load = (accept && !is_md) || calc_done;
  assign load_val = calc_done ? md_res : simple_res;
  // Result and zero flag are captured once per operation and held through DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      zero <= 1'b0;
    end else if (load) begin
      result <= load_val;
      zero <= load_val == '0;
    end
  end
  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? (is_md ? CALC : DONE) : IDLE;
      CALC: state_nx = calc_done ? DONE : CALC;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // Handshake outputs decoded from state
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = MD_EN && state == CALC;
  end
endmodule
